// File: rtl/l2_pmem_write_buffer.sv
// Posted write buffer between the L2 memory-side wishbone and pmem_master.
// Writes retire into a small FIFO and drain when the bus is free; reads hit the FIFO or go to pmem.
module l2_pmem_write_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 12,
  parameter int DW    = 128
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [AW-1:0]            s_ADR,
  input  logic [DW-1:0]            s_DAT_M,
  input  logic [DW/8-1:0]          s_SEL,
  input  logic                     s_CYC,
  input  logic                     s_STB,
  input  logic                     s_WE,
  output logic [DW-1:0]            s_DAT_S,
  output logic                     s_ACK,
  output logic                     s_RTY,
  output logic [AW-1:0]            m_ADR,
  output logic [DW-1:0]            m_DAT_M,
  output logic [DW/8-1:0]          m_SEL,
  output logic                     m_CYC,
  output logic                     m_STB,
  output logic                     m_WE,
  input  logic [DW-1:0]            m_DAT_S,
  input  logic                     m_ACK,
  input  logic                     m_RTY,
  output logic [1:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int SW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t          state;
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]   ent_adr [DEPTH];
  logic [DW-1:0]   ent_dat [DEPTH];
  logic [SW-1:0]   ent_sel [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;

  // Handshake: a request is live while CYC&STB are high and s_ACK is low; the L2
  // holds ADR/DAT/SEL/WE stable until the single-cycle registered s_ACK, which
  // completes it. The pmem side is the mirror image: m_* stay fixed from STB rise to m_ACK.
  logic            req, wr_req, rd_req, pop;
  logic [CW-1:0]   count_pop;
  logic            rd_hit, rd_full, wr_hit;
  logic            go_rd, start_wr, drain_head, rd_fast, wr_alloc, wr_merge;
  logic [PW-1:0]   rd_idx, rd_pos, wr_idx, wr_pos;
  logic            unused_rty;

  assign unused_rty = m_RTY;
  assign s_RTY      = 1'b0;
  assign dbg_state  = state;
  assign dbg_count  = count;

  assign req       = s_CYC & s_STB & ~s_ACK;
  assign wr_req    = req & s_WE;
  assign rd_req    = req & ~s_WE;
  assign pop       = (state == WR) & m_ACK;
  assign count_pop = count - CW'(pop);

  // Youngest valid entry matching the request address, scanning oldest to newest.
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = head;
    rd_pos = head;
    for (int k = 0; k < DEPTH; k++) begin
      rd_pos = head + PW'(k);
      if (CW'(k) < count && ent_vld[rd_pos] && ent_adr[rd_pos] == s_ADR) begin
        rd_hit = 1'b1;
        rd_idx = rd_pos;
      end
    end
  end

  assign rd_full    = &ent_sel[rd_idx];
  assign go_rd      = (state == IDLE) & rd_req & ~rd_hit & (count != FULL);
  assign start_wr   = (state == IDLE) & ~go_rd & (count != '0);
  assign drain_head = (state == WR) | start_wr;
  assign rd_fast    = rd_req & rd_hit & rd_full & ((state == IDLE) | (state == WR));

  // A head that is being (or about to be) written to pmem is frozen, so it is never a merge target.
  always_comb begin
    wr_hit = 1'b0;
    wr_idx = head;
    wr_pos = head;
    for (int k = 0; k < DEPTH; k++) begin
      wr_pos = head + PW'(k);
      if (CW'(k) < count && ent_vld[wr_pos] && ent_adr[wr_pos] == s_ADR &&
          !(drain_head && k == 0)) begin
        wr_hit = 1'b1;
        wr_idx = wr_pos;
      end
    end
  end

  assign wr_merge = wr_req & wr_hit;
  assign wr_alloc = wr_req & ~wr_hit & (count_pop < FULL);

  // Entry storage. Pop is applied before allocation so a full buffer can take a
  // write into the slot that frees in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ent_vld <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_adr[i] <= '0;
        ent_dat[i] <= '0;
        ent_sel[i] <= '0;
      end
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (wr_alloc) begin
        ent_vld[tail] <= 1'b1;
        ent_adr[tail] <= s_ADR;
        ent_dat[tail] <= s_DAT_M;
        ent_sel[tail] <= s_SEL;
        tail          <= tail + PW'(1);
      end
      if (wr_merge) begin
        for (int b = 0; b < SW; b++) begin
          if (s_SEL[b]) ent_dat[wr_idx][8*b +: 8] <= s_DAT_M[8*b +: 8];
        end
        ent_sel[wr_idx] <= ent_sel[wr_idx] | s_SEL;
      end
      count <= count - CW'(pop) + CW'(wr_alloc);
    end
  end

  // Bus FSM with registered outputs on both sides.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      s_ACK   <= 1'b0;
      s_DAT_S <= '0;
      m_CYC   <= 1'b0;
      m_STB   <= 1'b0;
      m_WE    <= 1'b0;
      m_ADR   <= '0;
      m_DAT_M <= '0;
      m_SEL   <= '0;
    end else begin
      s_ACK <= wr_alloc | wr_merge;
      if (rd_fast) begin
        s_ACK   <= 1'b1;
        s_DAT_S <= ent_dat[rd_idx];
      end
      case (state)
        IDLE: begin
          if (go_rd) begin
            state   <= RD;
            m_CYC   <= 1'b1;
            m_STB   <= 1'b1;
            m_WE    <= 1'b0;
            m_ADR   <= s_ADR;
            m_SEL   <= s_SEL;
            m_DAT_M <= '0;
          end else if (start_wr) begin
            state   <= WR;
            m_CYC   <= 1'b1;
            m_STB   <= 1'b1;
            m_WE    <= 1'b1;
            m_ADR   <= ent_adr[head];
            m_SEL   <= ent_sel[head];
            m_DAT_M <= ent_dat[head];
          end
        end
        RD: begin
          if (m_ACK) begin
            state   <= RESP;
            s_ACK   <= 1'b1;
            s_DAT_S <= m_DAT_S;
            m_CYC   <= 1'b0;
            m_STB   <= 1'b0;
            m_ADR   <= '0;
            m_SEL   <= '0;
          end
        end
        WR: begin
          if (m_ACK) begin
            state   <= IDLE;
            m_CYC   <= 1'b0;
            m_STB   <= 1'b0;
            m_WE    <= 1'b0;
            m_ADR   <= '0;
            m_SEL   <= '0;
            m_DAT_M <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_pmem_write_buffer.sv
// Directed bench for l2_pmem_write_buffer: vector table of L2 operations plus
// hand-written sequences for full-buffer, read priority, byte merge and reset.
module tb_l2_pmem_write_buffer;

  localparam int DEPTH = 2;
  localparam int AW    = 12;
  localparam int DW    = 128;
  localparam int SW    = DW / 8;

  logic            CLK, RST_N;
  logic [AW-1:0]   s_ADR;
  logic [DW-1:0]   s_DAT_M, s_DAT_S;
  logic [SW-1:0]   s_SEL;
  logic            s_CYC, s_STB, s_WE, s_ACK, s_RTY;
  logic [AW-1:0]   m_ADR;
  logic [DW-1:0]   m_DAT_M, m_DAT_S;
  logic [SW-1:0]   m_SEL;
  logic            m_CYC, m_STB, m_WE, m_ACK, m_RTY;
  logic [1:0]      dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;

  l2_pmem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .s_ADR(s_ADR), .s_DAT_M(s_DAT_M), .s_SEL(s_SEL), .s_CYC(s_CYC), .s_STB(s_STB),
    .s_WE(s_WE), .s_DAT_S(s_DAT_S), .s_ACK(s_ACK), .s_RTY(s_RTY),
    .m_ADR(m_ADR), .m_DAT_M(m_DAT_M), .m_SEL(m_SEL), .m_CYC(m_CYC), .m_STB(m_STB),
    .m_WE(m_WE), .m_DAT_S(m_DAT_S), .m_ACK(m_ACK), .m_RTY(m_RTY),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
  } txn_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    int            exp_lat;
    logic [DW-1:0] exp_rd;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   ack_delay = 0;
  txn_t log_q[$];
  txn_t exp_q[$];
  int   mack_q[$];

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{4'hC, a}};
  endfunction

  function automatic logic [DW-1:0] byte_mask(input logic [SW-1:0] sel);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < SW; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // pmem responder: acks after ack_delay cycles, logs every completed transfer,
  // and checks that the request is held stable while waiting.
  initial begin
    int   wait_cnt;
    logic in_txn;
    txn_t held, cur;
    m_ACK = 1'b0; m_DAT_S = '0; m_RTY = 1'b0;
    wait_cnt = 0; in_txn = 1'b0; held = '0;
    forever begin
      @(negedge CLK);
      cur = '{we: m_WE, adr: m_ADR, sel: m_SEL, dat: m_DAT_M};
      if (!RST_N) begin
        m_ACK = 1'b0; wait_cnt = 0; in_txn = 1'b0;
      end else if (m_ACK) begin
        m_ACK = 1'b0; in_txn = 1'b0;
      end else if (m_CYC && m_STB) begin
        if (in_txn) check("m_hold", cur, held);
        else begin held = cur; in_txn = 1'b1; end
        if (wait_cnt < ack_delay) wait_cnt++;
        else begin
          wait_cnt = 0;
          m_ACK = 1'b1;
          m_DAT_S = cur.we ? '0 : pat(cur.adr);
          log_q.push_back(cur);
          mack_q.push_back(cyc);
        end
      end
    end
  end

  // Driver tasks
  task automatic l2_op(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel, output int lat, output logic [DW-1:0] rdata,
                       output int ack_cyc);
    @(negedge CLK);
    s_CYC = 1'b1; s_STB = 1'b1; s_WE = we; s_ADR = adr; s_DAT_M = dat; s_SEL = sel;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!s_ACK && lat < 200);
    check("l2_ack_seen", s_ACK, 1'b1);
    rdata   = s_DAT_S;
    ack_cyc = cyc;
    s_CYC = 1'b0; s_STB = 1'b0; s_WE = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(m_CYC == 1'b0 && dbg_count == '0 && dbg_state == 2'd0) && n < 300);
    check(name, {m_CYC, dbg_count, dbg_state}, '0);
  endtask

  task automatic exp_push(input logic we, input logic [AW-1:0] adr, input logic [SW-1:0] sel,
                          input logic [DW-1:0] dat);
    exp_q.push_back('{we: we, adr: adr, sel: sel, dat: dat});
  endtask

  // Scoreboard: pmem transfers must match the expected queue in order.
  task automatic check_log(input string name);
    txn_t e, a;
    logic [DW-1:0] m;
    check({name, "_len"}, log_q.size(), exp_q.size());
    while (exp_q.size() > 0 && log_q.size() > 0) begin
      e = exp_q.pop_front();
      a = log_q.pop_front();
      check({name, "_hdr"}, {a.we, a.adr}, {e.we, e.adr});
      if (e.we) begin
        m = byte_mask(e.sel);
        check({name, "_sel"}, a.sel, e.sel);
        check({name, "_dat"}, a.dat & m, e.dat & m);
      end
    end
    exp_q.delete();
    log_q.delete();
  endtask

  localparam logic [DW-1:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] D4 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [DW-1:0] D5 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [DW-1:0] DA = 128'h1000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [DW-1:0] DB = 128'h2000_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [DW-1:0] DC = 128'h3000_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [DW-1:0] M1 = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
  localparam logic [DW-1:0] M2 = 128'h5555_5555_6666_6666_7777_7777_8888_8888;

  initial begin
    vec_t vecs[7];
    int lat, ack_c, base;
    logic [DW-1:0] rd;

    vecs[0] = '{1'b1, 12'h010, D1,     16'hFFFF, 1, 128'h0};
    vecs[1] = '{1'b0, 12'h010, 128'h0, 16'hFFFF, 1, D1};
    vecs[2] = '{1'b0, 12'h200, 128'h0, 16'hFFFF, 2, pat(12'h200)};
    vecs[3] = '{1'b1, 12'h300, D4,     16'hFFFF, 1, 128'h0};
    vecs[4] = '{1'b0, 12'h300, 128'h0, 16'hFFFF, 1, D4};
    vecs[5] = '{1'b1, 12'h310, D5,     16'h00FF, 1, 128'h0};
    vecs[6] = '{1'b0, 12'h310, 128'h0, 16'hFFFF, 3, pat(12'h310)};

    RST_N = 1'b0;
    s_CYC = 1'b0; s_STB = 1'b0; s_WE = 1'b0; s_ADR = '0; s_DAT_M = '0; s_SEL = '0;
    repeat (3) @(negedge CLK);
    check("rst_ctrl", {s_ACK, s_RTY, m_CYC, m_STB, m_WE}, '0);
    check("rst_mbus", {m_ADR, m_SEL, m_DAT_M}, '0);
    check("rst_sdat", s_DAT_S, '0);
    check("rst_fsm", {dbg_state, dbg_count}, '0);
    RST_N = 1'b1;

    // Vector table, zero-wait pmem, one idle cycle between L2 operations
    ack_delay = 0;
    for (int i = 0; i < 7; i++) begin
      l2_op(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, lat, rd, ack_c);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    wait_idle("tbl_idle");
    exp_push(1'b1, 12'h010, 16'hFFFF, D1);
    exp_push(1'b0, 12'h200, 16'hFFFF, 128'h0);
    exp_push(1'b1, 12'h300, 16'hFFFF, D4);
    exp_push(1'b1, 12'h310, 16'h00FF, D5);
    exp_push(1'b0, 12'h310, 16'hFFFF, 128'h0);
    check_log("tbl_log");

    // Full buffer: third write is acked the cycle after the head's m_ACK
    ack_delay = 4;
    base = mack_q.size();
    l2_op(1'b1, 12'h020, DA, 16'hFFFF, lat, rd, ack_c);
    check("full_w1_lat", lat, 1);
    l2_op(1'b1, 12'h030, DB, 16'hFFFF, lat, rd, ack_c);
    check("full_w2_lat", lat, 1);
    l2_op(1'b1, 12'h040, DC, 16'hFFFF, lat, rd, ack_c);
    check("full_w3_lat", lat, 3);
    check("full_w3_after_mack", ack_c, mack_q[base] + 1);
    wait_idle("full_idle");
    exp_push(1'b1, 12'h020, 16'hFFFF, DA);
    exp_push(1'b1, 12'h030, 16'hFFFF, DB);
    exp_push(1'b1, 12'h040, 16'hFFFF, DC);
    check_log("full_log");

    // Pending read miss wins over the remaining buffered write
    l2_op(1'b1, 12'h0A0, DA, 16'hFFFF, lat, rd, ack_c);
    l2_op(1'b1, 12'h020, DB, 16'hFFFF, lat, rd, ack_c);
    l2_op(1'b0, 12'h050, 128'h0, 16'hFFFF, lat, rd, ack_c);
    check("prio_rdata", rd, pat(12'h050));
    wait_idle("prio_idle");
    exp_push(1'b1, 12'h0A0, 16'hFFFF, DA);
    exp_push(1'b0, 12'h050, 16'hFFFF, 128'h0);
    exp_push(1'b1, 12'h020, 16'hFFFF, DB);
    check_log("prio_log");

    // Byte merge into a non-draining entry while the buffer is full
    ack_delay = 6;
    l2_op(1'b1, 12'h0B0, DC, 16'hFFFF, lat, rd, ack_c);
    l2_op(1'b1, 12'h060, M1, 16'h000F, lat, rd, ack_c);
    l2_op(1'b1, 12'h060, M2, 16'hFFF0, lat, rd, ack_c);
    check("merge_lat", lat, 1);
    check("merge_count", dbg_count, 2);
    wait_idle("merge_idle");
    exp_push(1'b1, 12'h0B0, 16'hFFFF, DC);
    exp_push(1'b1, 12'h060, 16'hFFFF, {M2[127:32], M1[31:0]});
    check_log("merge_log");

    // Reset while a pmem write waits for m_ACK
    ack_delay = 50;
    l2_op(1'b1, 12'h0C0, DA, 16'hFFFF, lat, rd, ack_c);
    @(negedge CLK);
    check("rst_wr_started", {m_STB, m_WE}, 2'b11);
    RST_N = 1'b0;
    #1;
    check("rst_mid_ctrl", {s_ACK, m_CYC, m_STB, m_WE}, '0);
    check("rst_mid_mbus", {m_ADR, m_SEL, m_DAT_M}, '0);
    check("rst_mid_sdat", s_DAT_S, '0);
    check("rst_mid_fsm", {dbg_state, dbg_count}, '0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("rst_after_quiet", {s_ACK, m_CYC, dbg_count}, '0);
    end
    check("rst_no_pmem", log_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
